// File: rtl/axil_reg_bank_if.sv
// AXI4-Lite signal bundle (AW, W, B, AR, R channels) shared by manager and subordinate.
// No logic or latency of its own; ready/valid handshakes are owned by the endpoints.
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport subordinate (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport manager (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axil_reg_bank.sv
// AXI4-Lite bank of NUM_REGS registers with per-register write strobe; read latency 1, write commits 1 cycle after AW+W held.
// Responses are held until bready/rready; AW/W/AR are refused while a transaction of that kind is in flight.
module axil_reg_bank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  axi4_if.subordinate                    s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);
  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam int          ADDR_LSB = $clog2(STRB_W);
  localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [63:0] LIMIT    = 64'(NUM_REGS * STRB_W);
  localparam logic [1:0]  OKAY     = 2'b00;
  localparam logic [1:0]  SLVERR   = 2'b10;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]     strb;
  } wbeat_t;

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP}           rstate_t;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < LIMIT;
  endfunction

  function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'(a >> ADDR_LSB);
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wstate_t               w_state, w_next;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr;
  wbeat_t                w_beat;
  logic                  w_hit;
  logic [IDX_W-1:0]      w_idx;
  logic [1:0]            bresp_q;

  rstate_t               r_state, r_next;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  assign w_hit = in_range(aw_addr);
  assign w_idx = reg_idx(aw_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Readies and bvalid come only from registered state, never from inputs.
  always_comb begin
    w_next         = w_state;
    s_axi.awready  = 1'b0;
    s_axi.wready   = 1'b0;
    s_axi.bvalid   = 1'b0;
    wr_pulse_o     = '0;
    unique case (w_state)
      W_IDLE: begin
        s_axi.awready = !aw_held;
        s_axi.wready  = !w_held;
        if ((aw_held || s_axi.awvalid) && (w_held || s_axi.wvalid)) w_next = W_COMMIT;
      end
      W_COMMIT: begin
        if (w_hit) wr_pulse_o = NUM_REGS'(1) << w_idx;
        w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_addr <= '0;
      w_beat  <= '0;
    end else if (w_state == W_IDLE) begin
      if (s_axi.awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi.awaddr;
      end
      if (s_axi.wvalid && !w_held) begin
        w_held <= 1'b1;
        w_beat <= '{data: s_axi.wdata, strb: s_axi.wstrb};
      end
    end else if (w_state == W_COMMIT) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      bresp_q <= OKAY;
    else if (w_state == W_COMMIT) bresp_q <= w_hit ? OKAY : SLVERR;
  end

  assign s_axi.bresp = bresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (w_state == W_COMMIT && w_hit) begin
      for (int k = 0; k < STRB_W; k++)
        if (w_beat.strb[k]) regs[w_idx][8*k +: 8] <= w_beat.data[8*k +: 8];
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) r_next = R_RESP;
      end
      R_RESP: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Sampled before the same-edge write lands, so a colliding read sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else if (r_state == R_IDLE && s_axi.arvalid) begin
      if (in_range(s_axi.araddr)) begin
        rdata_q <= regs[reg_idx(s_axi.araddr)];
        rresp_q <= OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= SLVERR;
      end
    end
  end

  assign s_axi.rdata = rdata_q;
  assign s_axi.rresp = rresp_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot};
endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: 8 x 32-bit registers, inputs driven and outputs sampled on the falling edge.
module tb_axil_reg_bank;
  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] regs_o;
  logic [7:0]   wr_pulse_o;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axil_reg_bank #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (8),
    .RESET_VAL (32'h0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (axi),
    .regs_o    (regs_o),
    .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [8] = '{default: 0};
  int snap [8];
  logic [255:0] exp_regs;

  always @(negedge clk)
    for (int i = 0; i < 8; i++) if (wr_pulse_o[i] === 1'b1) pulse_cnt[i]++;

  function automatic int pulse_total();
    int t = 0;
    for (int i = 0; i < 8; i++) t += pulse_cnt[i];
    return t;
  endfunction

  function automatic int snap_total();
    int t = 0;
    for (int i = 0; i < 8; i++) t += snap[i];
    return t;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata  = d; axi.wstrb   = s; axi.wvalid = 1'b1;
    while (!(axi.awready && axi.wready) && n < 50) begin @(negedge clk); n++; end
    check("wr_accept_in_time", 256'(n < 50), 256'(1));
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp);
    int n = 0;
    while (axi.bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check({tag, "_bvalid"}, 256'(axi.bvalid), 256'(1));
    check({tag, "_bresp"}, 256'(axi.bresp), 256'(exp));
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check({tag, "_bvalid_clr"}, 256'(axi.bvalid), 256'(0));
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n = 0;
    @(negedge clk);
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!axi.arready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ar_in_time"}, 256'(n < 50), 256'(1));
    @(negedge clk);
    axi.arvalid = 1'b0;
    check({tag, "_rvalid"}, 256'(axi.rvalid), 256'(1));
    check({tag, "_rdata"}, 256'(axi.rdata), 256'(exp_d));
    check({tag, "_rresp"}, 256'(axi.rresp), 256'(exp_r));
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check({tag, "_rvalid_clr"}, 256'(axi.rvalid), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
    axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = 3'b111; axi.arvalid = 1'b0;
    axi.rready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", 256'(axi.awready), 256'(1));
    check("rst_wready", 256'(axi.wready), 256'(1));
    check("rst_arready", 256'(axi.arready), 256'(1));
    check("rst_bvalid", 256'(axi.bvalid), 256'(0));
    check("rst_bresp", 256'(axi.bresp), 256'(0));
    check("rst_rvalid", 256'(axi.rvalid), 256'(0));
    check("rst_rresp", 256'(axi.rresp), 256'(0));
    check("rst_rdata", 256'(axi.rdata), 256'(0));
    check("rst_wr_pulse", 256'(wr_pulse_o), 256'(0));
    check("rst_regs", regs_o, 256'(0));
    rst = 1'b0;
    exp_regs = '0;

    // AW and W together to reg1
    snap = pulse_cnt;
    wr_both(32'h4, 32'hDEADBEEF, 4'hF);
    wait_b("full_wr", 2'b00);
    check("full_wr_pulse1", 256'(pulse_cnt[1]), 256'(snap[1] + 1));
    check("full_wr_pulse_total", 256'(pulse_total()), 256'(snap_total() + 1));
    exp_regs[63:32] = 32'hDEADBEEF;
    check("full_wr_regs", regs_o, exp_regs);
    rd("full_rd", 32'h4, 32'hDEADBEEF, 2'b00);

    // W three cycles ahead of AW, partial strobe on reg0
    wr_both(32'h0, 32'hAAAAAAAA, 4'hF);
    wait_b("pre_wr", 2'b00);
    @(negedge clk);
    axi.wdata = 32'h12345678; axi.wstrb = 4'h3; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.wvalid = 1'b0;
    check("w_first_wready", 256'(axi.wready), 256'(0));
    check("w_first_awready", 256'(axi.awready), 256'(1));
    check("w_first_no_b", 256'(axi.bvalid), 256'(0));
    repeat (2) @(negedge clk);
    axi.awaddr = 32'h0; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    wait_b("w_first", 2'b00);
    exp_regs[31:0] = 32'hAAAA5678;
    check("w_first_regs", regs_o, exp_regs);

    // Out-of-range write and read
    snap = pulse_cnt;
    wr_both(32'h20, 32'hFFFFFFFF, 4'hF);
    wait_b("oor_wr", 2'b10);
    check("oor_no_pulse", 256'(pulse_total()), 256'(snap_total()));
    check("oor_regs", regs_o, exp_regs);
    rd("oor_rd", 32'h20, 32'h0, 2'b10);

    // Responses held under backpressure
    wr_both(32'hC, 32'h33, 4'hF);
    @(negedge clk);
    axi.araddr = 32'h4; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("hold_bvalid", 256'(axi.bvalid), 256'(1));
      check("hold_bresp", 256'(axi.bresp), 256'(0));
      check("hold_rvalid", 256'(axi.rvalid), 256'(1));
      check("hold_rdata", 256'(axi.rdata), 256'(32'hDEADBEEF));
      check("hold_rresp", 256'(axi.rresp), 256'(0));
      check("hold_awready", 256'(axi.awready), 256'(0));
      check("hold_wready", 256'(axi.wready), 256'(0));
      check("hold_arready", 256'(axi.arready), 256'(0));
      @(negedge clk);
    end
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;
    check("hold_bvalid_clr", 256'(axi.bvalid), 256'(0));
    check("hold_rvalid_clr", 256'(axi.rvalid), 256'(0));
    exp_regs[127:96] = 32'h33;
    check("hold_regs", regs_o, exp_regs);

    // Read colliding with commit to the same register
    wr_both(32'h8, 32'h1, 4'hF);
    wait_b("col_pre", 2'b00);
    @(negedge clk);
    axi.awaddr = 32'h8; axi.awvalid = 1'b1;
    axi.wdata = 32'h5; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.araddr = 32'h8; axi.arvalid = 1'b1;
    check("col_commit_pulse", 256'(wr_pulse_o), 256'(8'b0000_0100));
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("col_rvalid", 256'(axi.rvalid), 256'(1));
    check("col_rdata_old", 256'(axi.rdata), 256'(32'h1));
    check("col_pulse_gone", 256'(wr_pulse_o), 256'(0));
    exp_regs[95:64] = 32'h5;
    check("col_regs_new", regs_o, exp_regs);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    wait_b("col_wr", 2'b00);
    rd("col_rd_new", 32'h8, 32'h5, 2'b00);

    // Zero strobe: OKAY, pulse, no data change
    snap = pulse_cnt;
    wr_both(32'h4, 32'hFFFFFFFF, 4'h0);
    wait_b("zstrb", 2'b00);
    check("zstrb_pulse", 256'(pulse_cnt[1]), 256'(snap[1] + 1));
    check("zstrb_regs", regs_o, exp_regs);

    // Reset mid-transaction, after AW only
    @(negedge clk);
    axi.awaddr = 32'h8; axi.awvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    check("mid_aw_held", 256'(axi.awready), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_awready", 256'(axi.awready), 256'(1));
    check("mid_wready", 256'(axi.wready), 256'(1));
    check("mid_arready", 256'(axi.arready), 256'(1));
    for (int i = 0; i < 5; i++) begin
      check("mid_no_bvalid", 256'(axi.bvalid), 256'(0));
      @(negedge clk);
    end
    check("mid_regs_reset", regs_o, 256'(0));
    check("mid_no_pulse", 256'(wr_pulse_o), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_reg_bank.md
AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; legal values 1..256.
REQ-004 SHALL have parameter RESET_VAL, default 0, reset value of every register (DATA_WIDTH bits).
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port s_axi  interface  axi4_if.subordinate (ADDR_WIDTH, DATA_WIDTH)  AXI4-Lite subordinate port, all five channels.
REQ-008 SHALL have port regs_o  output  NUM_REGS*DATA_WIDTH  register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port wr_pulse_o  output  NUM_REGS  one-cycle strobe per register on each committed write.

Function
REQ-010 SHALL decode index = addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored; addr >= NUM_REGS*DATA_WIDTH/8 is out of range.
REQ-011 SHALL ignore awprot and arprot.
REQ-012 SHALL run an independent write FSM with states W_IDLE, W_COMMIT, W_RESP.
REQ-013 In W_IDLE: awready=1 until AW captured, wready=1 until W captured; AW and W accepted in either order or the same cycle, each held in a holding register.
REQ-014 SHALL move W_IDLE -> W_COMMIT on the edge at which both AW and W are held.
REQ-015 In W_COMMIT (one cycle): in-range index -> byte lanes with wstrb[k]=1 updated, others unchanged, wr_pulse_o[index]=1 for that cycle; out-of-range -> no register change, no pulse.
REQ-016 SHALL move W_COMMIT -> W_RESP; bvalid=1 from that edge, bresp=2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range.
REQ-017 SHALL hold bvalid and bresp stable until bready=1; then W_RESP -> W_IDLE and bvalid=0 next cycle.
REQ-018 awready=wready=0 in W_COMMIT and W_RESP; one write outstanding at most.
REQ-019 SHALL write data with wstrb=0 as an OKAY write that changes no bits but still pulses wr_pulse_o.
REQ-020 SHALL run an independent read FSM with states R_IDLE, R_RESP.
REQ-021 In R_IDLE: arready=1; on AR handshake at edge N, rdata is registered at edge N and rvalid=1 from edge N (latency 1 cycle).
REQ-022 rdata = register value at edge N with rresp=2'b00 in range; rdata=0 with rresp=2'b10 out of range.
REQ-023 SHALL hold rvalid, rdata, rresp stable until rready=1; then R_RESP -> R_IDLE; arready=0 in R_RESP.
REQ-024 AR handshake in the same cycle as a W_COMMIT to the same register: rdata SHALL return the pre-write value.
REQ-025 regs_o SHALL reflect a committed write from the edge leaving W_COMMIT.
REQ-026 SHALL never drop or reorder accepted transactions; no combinational path from any input to any valid/ready output.

Reset
REQ-027 While rst=1: write FSM in W_IDLE, read FSM in R_IDLE, holding registers cleared.
REQ-028 Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0, wr_pulse_o=0, every register = RESET_VAL.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no register update and no response after release.

Verification
REQ-030 AW+W same cycle, addr 0x4, wdata 0xDEADBEEF, wstrb 0xF -> wr_pulse_o[1] pulses once; bvalid with bresp 00; read 0x4 returns 0xDEADBEEF, rresp 00.
REQ-031 W three cycles before AW to addr 0x0, wstrb 0x3, data 0x12345678, reg0=0xAAAAAAAA -> reg0 = 0xAAAA5678, bresp 00.
REQ-032 Write and read to addr 0x20 (NUM_REGS=8) -> bresp 10, rresp 10, rdata 0, no wr_pulse_o, regs unchanged.
REQ-033 bready and rready held low 10 cycles -> bvalid/rvalid, bresp/rresp and rdata stable; awready, wready, arready stay 0.
REQ-034 Read reg2 concurrent with W_COMMIT of 0x5 to reg2 (old value 0x1) -> rdata 0x1; a subsequent read returns 0x5.
REQ-035 rst pulsed after AW handshake, before W -> no bvalid after release, all regs = RESET_VAL, all readys = 1.
